decode_stage: RTL
=================

Name: decode_stage

Overview:
- Registered, parametrised successor to the combinational instruction decoder of the Jac1-8 core.
- Sits between program ROM/PC and register file/ALU, with one cycle of decode latency.
- Decodes the full arithmetic set (ADD/SUB/AND/OR/NOT/XOR/SHL/SHR/VAL) and GOTO.
- Adds conditional flow: IFZ/IFNZ branch on the stored ALU flags. IFEQ/IFST/IFGT are two-cycle compare-and-skip ops, implemented by a small FSM with PC hold and next-instruction squash.

Parameters:
- DataWidth, 8, register/literal width.
- SEL_WIDTH, 2, register select width (2^SEL_WIDTH registers).
- PROGRAM_DataWidth, 16, instruction width.
- NumOpCodeBits, 5, opcode width; opcode = instruction[PROGRAM_DataWidth-1 -: NumOpCodeBits].
- NumStatusBits, 2, flag width; bit0 = Z (result zero), bit1 = N (borrow/negative).
- OP1_BIT_POS, 9, MSB of op1 field; field = instruction[OP1_BIT_POS -: SEL_WIDTH].
- OP2_BIT_POS, 4, MSB of op2 field; field = instruction[OP2_BIT_POS -: SEL_WIDTH].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction input is meaningful this cycle.
- instruction  in  PROGRAM_DataWidth  instruction word from program memory.
- status  in  NumStatusBits  registered ALU flags; updated by the ALU at an edge where flag_upd=1.
- alu_op  out  NumOpCodeBits  operation for the ALU (opcode, or Op_SUB during a compare).
- literal_adr  out  DataWidth  instruction[DataWidth-1:0]; literal value or branch target.
- param  out  DataWidth  instruction[DataWidth-1:0]; shift amount for SHL/SHR.
- rd_sel1, rd_sel2, wr_sel  out  SEL_WIDTH each  register selects.
- rd_en1, rd_en2, wr_en  out  1 each  register file enables.
- sel_reg_in_alu_decoder  out  1  register write source; 1 = ALU, 0 = decoder literal.
- flag_upd  out  1  ALU must capture flags at the end of this cycle.
- cnt_wr_en  out  1  load PC with literal_adr.
- pc_hold  out  1  PC must not advance.
- squashed  out  1  current output cycle is a skipped instruction.
- illegal  out  1  reserved opcode was decoded.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs 0; alu_op = Op_NOP.
  - state = DECODE; skip_pending = 0.
  - Release is synchronous to the next clk edge.
- Latency: every output is a flop. An instruction sampled at edge k drives outputs from edge k to edge k+1.
- In DECODE with instr_valid=0: NOP bubble (all enables 0, pc_hold 0). skip_pending is retained.
- In DECODE with skip_pending=1 and instr_valid=1:
  - Output is a NOP with squashed=1; skip_pending clears.
  - A squashed branch or compare has no effect.
- Arithmetic decode:
  - ADD, SUB, AND, OR, XOR: rd_sel1 = wr_sel = op1, rd_sel2 = op2; rd_en1 = rd_en2 = wr_en = 1; ALU source; flag_upd = 1.
  - NOT: rd_en1 = 0, rd_sel1 = 0, rd_sel2 = op2, wr_sel = op1; rd_en2 = wr_en = 1; ALU source; flag_upd = 1.
  - SHL, SHR: rd_sel1 = wr_sel = op1, rd_en1 = 1, rd_en2 = 0; wr_en = 1; ALU source; flag_upd = 1; param carries the amount.
  - VAL: wr_sel = op1, wr_en = 1, decoder source; flag_upd = 0.
- GOTO: cnt_wr_en = 1.
- IFZ: cnt_wr_en = status[0].
- IFNZ: cnt_wr_en = !status[0].
- Compare ops (IFEQ, IFST, IFGT), FSM DECODE -> CMP_ISSUE -> CMP_WAIT -> DECODE:
  - Decode edge (enter CMP_ISSUE): outputs alu_op = Op_SUB, rd_sel1 = op1, rd_sel2 = op2, rd_en1 = rd_en2 = 1, wr_en = 0, flag_upd = 1, pc_hold = 1; the condition code is latched.
  - Next edge (enter CMP_WAIT): NOP outputs, pc_hold = 1; instruction input is ignored.
  - Edge leaving CMP_WAIT: status is evaluated (EQ: Z; ST: N; GT: !Z & !N). If the condition is false, skip_pending is set. State returns to DECODE and that edge decodes nothing (NOP, pc_hold = 0).
- Reserved opcodes: NOP outputs with illegal = 1 for that cycle.
- Registers, widths and edges:
  - Register selects are truncated to SEL_WIDTH.
  - No arithmetic is done inside this block.
  - Reset in any state aborts a compare and clears skip_pending.

Decomposition:
- Package jac_pkg: opcode constants (Op_NOP..Op_IFGT, reserved), SEL_ALU/SEL_DECODER, status bit indices Z_BIT/N_BIT, FSM state enum.
- One sub-module, jac_cond_eval: combinational (cond_code, status) -> take. It is shared by IFZ/IFNZ and the compare ops.

Test Plan:
- Reset mid-compare: rst_n low while state = CMP_WAIT -> all outputs 0, state DECODE, skip_pending 0, no squash on the next instruction.
- Register-source ADD: ADD op1=2, op2=1 (0x0A08) -> one edge later rd_sel1 = 2, rd_sel2 = 1, wr_sel = 2, rd_en1 = rd_en2 = wr_en = 1, sel = 1, flag_upd = 1; following instr_valid = 0 -> all enables 0.
- Literal VAL: VAL r3, 0x5A (0x4B5A) -> wr_sel = 3, wr_en = 1, sel = 0, literal_adr = 0x5A.
- IFZ taken and not taken: IFZ 0x40 with status = 01 -> cnt_wr_en = 1, literal_adr = 0x40; with status = 00 -> cnt_wr_en = 0.
- IFEQ false: IFEQ r1, r2 -> issue cycle alu_op = SUB, pc_hold = 1, flag_upd = 1. Drive status = 00 during CMP_WAIT. The next valid ADD is then output as NOP with squashed = 1, and the ADD after it decodes normally.
- IFGT true with reserved opcode: IFGT with status = 00 in CMP_WAIT -> no squash. A following opcode 0x0A -> illegal = 1 with all enables 0.

Source files
------------

// File: rtl/jac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jac_pkg
// Description : Shared constants for the Jac1-8 decode stage: opcodes,
//               register-write source selects, flag bit indices, FSM states
//               and condition codes.
// Revision    : 1.0 - initial registered decode stage
// ============================================================================
package jac_pkg;

    localparam int OPCODE_BITS = 5;
    typedef logic [OPCODE_BITS-1:0] opcode_t;

    // Opcode map; 0x0A and 0x11..0x1F are reserved
    localparam opcode_t Op_NOP  = 5'h00;
    localparam opcode_t Op_ADD  = 5'h01;
    localparam opcode_t Op_SUB  = 5'h02;
    localparam opcode_t Op_AND  = 5'h03;
    localparam opcode_t Op_OR   = 5'h04;
    localparam opcode_t Op_NOT  = 5'h05;
    localparam opcode_t Op_XOR  = 5'h06;
    localparam opcode_t Op_SHL  = 5'h07;
    localparam opcode_t Op_SHR  = 5'h08;
    localparam opcode_t Op_VAL  = 5'h09;
    localparam opcode_t Op_RSVD = 5'h0A;
    localparam opcode_t Op_GOTO = 5'h0B;
    localparam opcode_t Op_IFZ  = 5'h0C;
    localparam opcode_t Op_IFNZ = 5'h0D;
    localparam opcode_t Op_IFEQ = 5'h0E;
    localparam opcode_t Op_IFST = 5'h0F;
    localparam opcode_t Op_IFGT = 5'h10;

    // Register file write source
    localparam logic SEL_ALU     = 1'b1;
    localparam logic SEL_DECODER = 1'b0;

    // Status flag bit positions
    localparam int Z_BIT = 0;
    localparam int N_BIT = 1;

    // Decode FSM states
    localparam logic [1:0] ST_DECODE    = 2'd0;
    localparam logic [1:0] ST_CMP_ISSUE = 2'd1;
    localparam logic [1:0] ST_CMP_WAIT  = 2'd2;

    // Condition codes evaluated by jac_cond_eval
    localparam logic [2:0] CC_Z  = 3'd0;
    localparam logic [2:0] CC_NZ = 3'd1;
    localparam logic [2:0] CC_EQ = 3'd2;
    localparam logic [2:0] CC_ST = 3'd3;
    localparam logic [2:0] CC_GT = 3'd4;

    // True for opcodes with no defined behaviour
    function automatic logic is_reserved(input opcode_t op);
        return (op == Op_RSVD) || (op > Op_IFGT);
    endfunction

    // Condition code latched by a compare-and-skip opcode
    function automatic logic [2:0] cmp_cc(input opcode_t op);
        case (op)
            Op_IFEQ: return CC_EQ;
            Op_IFST: return CC_ST;
            default: return CC_GT;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/jac_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : jac_cond_eval
// Description : Combinational branch/compare condition evaluator. Shared by
//               IFZ/IFNZ (at decode) and IFEQ/IFST/IFGT (leaving CMP_WAIT).
// Revision    : 1.0 - initial version
// ============================================================================
module jac_cond_eval
    import jac_pkg::*;
#(
    parameter int NUM_STATUS_BITS = 2
) (
    input  logic [2:0]                 cond_code,
    input  logic [NUM_STATUS_BITS-1:0] status,
    output logic                       take
);

    logic w_z;
    logic w_n;

    assign w_z = status[Z_BIT];
    assign w_n = status[N_BIT];

    // Map condition code onto the stored Z/N flags
    always_comb begin
        take = 1'b0;
        case (cond_code)
            CC_Z:    take = w_z;
            CC_NZ:   take = !w_z;
            CC_EQ:   take = w_z;
            CC_ST:   take = w_n;
            CC_GT:   take = !w_z && !w_n;
            default: take = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Registered Jac1-8 instruction decoder with one cycle of
//               latency. Handles arithmetic, GOTO, IFZ/IFNZ, and two-cycle
//               compare-and-skip ops (IFEQ/IFST/IFGT) with PC hold and
//               squash of the following instruction.
// Revision    : 1.0 - initial registered decode stage
// ============================================================================
module decode_stage
    import jac_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int SEL_WIDTH          = 2,
    parameter int PROGRAM_DATA_WIDTH = 16,
    parameter int NUM_OPCODE_BITS    = 5,
    parameter int NUM_STATUS_BITS    = 2,
    parameter int OP1_BIT_POS        = 9,
    parameter int OP2_BIT_POS        = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          instr_valid,
    input  logic [PROGRAM_DATA_WIDTH-1:0] instruction,
    input  logic [NUM_STATUS_BITS-1:0]    status,
    output logic [NUM_OPCODE_BITS-1:0]    alu_op,
    output logic [DATA_WIDTH-1:0]         literal_adr,
    output logic [DATA_WIDTH-1:0]         param,
    output logic [SEL_WIDTH-1:0]          rd_sel1,
    output logic [SEL_WIDTH-1:0]          rd_sel2,
    output logic [SEL_WIDTH-1:0]          wr_sel,
    output logic                          rd_en1,
    output logic                          rd_en2,
    output logic                          wr_en,
    output logic                          sel_reg_in_alu_decoder,
    output logic                          flag_upd,
    output logic                          cnt_wr_en,
    output logic                          pc_hold,
    output logic                          squashed,
    output logic                          illegal
);

    // Instruction fields
    opcode_t                 w_opcode;
    logic [SEL_WIDTH-1:0]    w_op1;
    logic [SEL_WIDTH-1:0]    w_op2;
    logic [DATA_WIDTH-1:0]   w_lit;
    logic                    w_unused;

    assign w_opcode = opcode_t'(instruction[PROGRAM_DATA_WIDTH-1 -: NUM_OPCODE_BITS]);
    assign w_op1    = instruction[OP1_BIT_POS -: SEL_WIDTH];
    assign w_op2    = instruction[OP2_BIT_POS -: SEL_WIDTH];
    assign w_lit    = instruction[DATA_WIDTH-1:0];
    assign w_unused = ^instruction;

    // FSM state
    logic [1:0] r_state;
    logic       r_skip;
    logic [2:0] r_cond;

    // Condition evaluation: latched compare code while waiting, else IFZ/IFNZ
    logic [2:0] w_cc;
    logic       w_take;

    assign w_cc = (r_state == ST_CMP_WAIT) ? r_cond :
                  (w_opcode == Op_IFNZ)    ? CC_NZ  : CC_Z;

    jac_cond_eval #(
        .NUM_STATUS_BITS (NUM_STATUS_BITS)
    ) u_cond_eval (
        .cond_code (w_cc),
        .status    (status),
        .take      (w_take)
    );

    // Next-cycle values
    opcode_t               w_alu_op;
    logic [DATA_WIDTH-1:0] w_lit_nx;
    logic [SEL_WIDTH-1:0]  w_rd_sel1;
    logic [SEL_WIDTH-1:0]  w_rd_sel2;
    logic [SEL_WIDTH-1:0]  w_wr_sel;
    logic                  w_rd_en1;
    logic                  w_rd_en2;
    logic                  w_wr_en;
    logic                  w_src;
    logic                  w_flag_upd;
    logic                  w_cnt_wr_en;
    logic                  w_pc_hold;
    logic                  w_squashed;
    logic                  w_illegal;
    logic [1:0]            w_state_nx;
    logic                  w_skip_nx;
    logic [2:0]            w_cond_nx;

    // Decode and FSM next-state logic; defaults describe a NOP bubble
    always_comb begin
        w_alu_op    = Op_NOP;
        w_lit_nx    = '0;
        w_rd_sel1   = '0;
        w_rd_sel2   = '0;
        w_wr_sel    = '0;
        w_rd_en1    = 1'b0;
        w_rd_en2    = 1'b0;
        w_wr_en     = 1'b0;
        w_src       = SEL_DECODER;
        w_flag_upd  = 1'b0;
        w_cnt_wr_en = 1'b0;
        w_pc_hold   = 1'b0;
        w_squashed  = 1'b0;
        w_illegal   = 1'b0;
        w_state_nx  = r_state;
        w_skip_nx   = r_skip;
        w_cond_nx   = r_cond;

        case (r_state)
            ST_DECODE: begin
                if (instr_valid) begin
                    if (r_skip) begin
                        w_squashed = 1'b1;
                        w_skip_nx  = 1'b0;
                    end else begin
                        if (!is_reserved(w_opcode) && (w_opcode != Op_NOP)) begin
                            w_alu_op = w_opcode;
                            w_lit_nx = w_lit;
                        end
                        case (w_opcode)
                            Op_ADD, Op_SUB, Op_AND, Op_OR, Op_XOR: begin
                                w_rd_sel1  = w_op1;
                                w_rd_sel2  = w_op2;
                                w_wr_sel   = w_op1;
                                w_rd_en1   = 1'b1;
                                w_rd_en2   = 1'b1;
                                w_wr_en    = 1'b1;
                                w_src      = SEL_ALU;
                                w_flag_upd = 1'b1;
                            end
                            Op_NOT: begin
                                w_rd_sel2  = w_op2;
                                w_wr_sel   = w_op1;
                                w_rd_en2   = 1'b1;
                                w_wr_en    = 1'b1;
                                w_src      = SEL_ALU;
                                w_flag_upd = 1'b1;
                            end
                            Op_SHL, Op_SHR: begin
                                w_rd_sel1  = w_op1;
                                w_wr_sel   = w_op1;
                                w_rd_en1   = 1'b1;
                                w_wr_en    = 1'b1;
                                w_src      = SEL_ALU;
                                w_flag_upd = 1'b1;
                            end
                            Op_VAL: begin
                                w_wr_sel = w_op1;
                                w_wr_en  = 1'b1;
                            end
                            Op_GOTO: begin
                                w_cnt_wr_en = 1'b1;
                            end
                            Op_IFZ, Op_IFNZ: begin
                                w_cnt_wr_en = w_take;
                            end
                            Op_IFEQ, Op_IFST, Op_IFGT: begin
                                // Compare is a subtraction whose only result is the flags
                                w_alu_op   = Op_SUB;
                                w_rd_sel1  = w_op1;
                                w_rd_sel2  = w_op2;
                                w_rd_en1   = 1'b1;
                                w_rd_en2   = 1'b1;
                                w_flag_upd = 1'b1;
                                w_pc_hold  = 1'b1;
                                w_cond_nx  = cmp_cc(w_opcode);
                                w_state_nx = ST_CMP_ISSUE;
                            end
                            Op_NOP: begin
                            end
                            default: begin
                                w_illegal = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ST_CMP_ISSUE: begin
                // ALU captures the compare flags at this edge
                w_pc_hold  = 1'b1;
                w_state_nx = ST_CMP_WAIT;
            end
            ST_CMP_WAIT: begin
                // Flags are now stable; a false condition skips the next instruction
                w_skip_nx  = !w_take;
                w_state_nx = ST_DECODE;
            end
            default: begin
                w_state_nx = ST_DECODE;
            end
        endcase
    end

    // Output and FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op                 <= NUM_OPCODE_BITS'(Op_NOP);
            literal_adr            <= '0;
            param                  <= '0;
            rd_sel1                <= '0;
            rd_sel2                <= '0;
            wr_sel                 <= '0;
            rd_en1                 <= 1'b0;
            rd_en2                 <= 1'b0;
            wr_en                  <= 1'b0;
            sel_reg_in_alu_decoder <= 1'b0;
            flag_upd               <= 1'b0;
            cnt_wr_en              <= 1'b0;
            pc_hold                <= 1'b0;
            squashed               <= 1'b0;
            illegal                <= 1'b0;
            r_state                <= ST_DECODE;
            r_skip                 <= 1'b0;
            r_cond                 <= CC_Z;
        end else begin
            alu_op                 <= NUM_OPCODE_BITS'(w_alu_op);
            literal_adr            <= w_lit_nx;
            param                  <= w_lit_nx;
            rd_sel1                <= w_rd_sel1;
            rd_sel2                <= w_rd_sel2;
            wr_sel                 <= w_wr_sel;
            rd_en1                 <= w_rd_en1;
            rd_en2                 <= w_rd_en2;
            wr_en                  <= w_wr_en;
            sel_reg_in_alu_decoder <= w_src;
            flag_upd               <= w_flag_upd;
            cnt_wr_en              <= w_cnt_wr_en;
            pc_hold                <= w_pc_hold;
            squashed               <= w_squashed;
            illegal                <= w_illegal;
            r_state                <= w_state_nx;
            r_skip                 <= w_skip_nx;
            r_cond                 <= w_cond_nx;
        end
    end

endmodule
`default_nettype wire
